// File: rtl/shift_unit_seq.sv
// Multi-cycle shifter: shifts/rotates an operand by at most STEP bits per cycle,
// with a valid/ready request side and a held result until the consumer accepts it.
module shift_unit_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       Operation,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] salida_o,
  output logic             busy_o
);

  localparam int unsigned AW = $clog2(WIDTH);
  localparam logic [AW-1:0] StepW = AW'(STEP);

  localparam logic [2:0] OpSll = 3'b000;
  localparam logic [2:0] OpSrl = 3'b001;
  localparam logic [2:0] OpSra = 3'b010;
  localparam logic [2:0] OpRol = 3'b011;
  localparam logic [2:0] OpRor = 3'b100;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] work_q;
  logic [AW-1:0]    rem_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] salida_q;

  logic [AW-1:0]    amount;
  logic             pass_through;
  logic [AW-1:0]    step_amt;
  logic [AW:0]      inv_amt;
  logic [WIDTH-1:0] work_nxt;

  // Only the low log2(WIDTH) bits of the shift amount are meaningful.
  logic unused_b_hi;
  assign unused_b_hi = ^B[WIDTH-1:AW];

  assign amount       = B[AW-1:0];
  assign pass_through = (Operation > OpRor) || (amount == '0);

  always_comb begin
    step_amt = (rem_q < StepW) ? rem_q : StepW;
    inv_amt  = (AW+1)'(WIDTH) - {1'b0, step_amt};
    work_nxt = work_q;
    case (op_q)
      OpSll:   work_nxt = work_q << step_amt;
      OpSrl:   work_nxt = work_q >> step_amt;
      // The working MSB is never vacated, so it carries the captured sign throughout.
      OpSra:   work_nxt = WIDTH'($signed(work_q) >>> step_amt);
      OpRol:   work_nxt = (work_q << step_amt) | (work_q >> inv_amt);
      OpRor:   work_nxt = (work_q >> step_amt) | (work_q << inv_amt);
      default: work_nxt = work_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      work_q   <= '0;
      rem_q    <= '0;
      op_q     <= '0;
      salida_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            op_q <= Operation;
            if (pass_through) begin
              salida_q <= A;
              state_q  <= StDone;
            end else begin
              work_q  <= A;
              rem_q   <= amount;
              state_q <= StBusy;
            end
          end
        end
        StBusy: begin
          work_q <= work_nxt;
          rem_q  <= rem_q - step_amt;
          if (rem_q == step_amt) begin
            salida_q <= work_nxt;
            state_q  <= StDone;
          end
        end
        StDone: begin
          if (out_ready_i) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign busy_o      = (state_q != StIdle);
  assign salida_o    = salida_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Bench for shift_unit_seq: directed vector table, random requests against a reference
// model, plus backpressure and mid-operation reset sequences.
module tb_shift_unit_seq;

  logic        clk;
  logic        reset;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  Operation;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] salida_o;
  logic        busy_o;

  int n_cmp = 0;
  int n_err = 0;

  shift_unit_seq #(
    .WIDTH(32),
    .STEP (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .A          (A),
    .B          (B),
    .Operation  (Operation),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .salida_o   (salida_o),
    .busy_o     (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] res;
    int          cyc;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
    int          n;
    logic [63:0] d;
    logic [63:0] t;
    logic [31:0] fill;
    n = int'(b % 32);
    d = {a, a};
    case (op)
      3'd0: ref_shift = a << n;
      3'd1: ref_shift = a >> n;
      3'd2: begin
        fill = a[31] ? ~(32'hFFFF_FFFF >> n) : 32'h0;
        ref_shift = (a >> n) | fill;
      end
      3'd3: begin
        t = d << n;
        ref_shift = t[63:32];
      end
      3'd4: begin
        t = d >> n;
        ref_shift = t[31:0];
      end
      default: ref_shift = a;
    endcase
  endfunction

  function automatic int ref_cycles(input logic [31:0] b, input logic [2:0] op);
    int n;
    n = int'(b % 32);
    if (n == 0 || op > 3'd4) ref_cycles = 1;
    else ref_cycles = (n + 3) / 4 + 1;
  endfunction

  // Issue one request, measure the cycle at which out_valid_o rises, hold the result for
  // `hold` cycles, then hand it off.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input int exp_cyc, input logic [31:0] exp_res, input int hold,
                        input string name);
    int          cyc;
    int          guard;
    logic [31:0] held;
    guard = 0;
    while (!in_ready_o && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check({name, " ready"}, 64'(in_ready_o), 64'd1);
    A = a; B = b; Operation = op; in_valid_i = 1'b1;
    @(posedge clk); #1;
    A = $urandom; B = $urandom; Operation = 3'($urandom);
    in_valid_i = 1'($urandom);
    cyc = 1;
    while (!out_valid_o && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      in_valid_i = 1'($urandom);
    end
    in_valid_i = 1'b0;
    check({name, " latency"}, 64'(cyc), 64'(exp_cyc));
    check({name, " result"}, 64'(salida_o), 64'(exp_res));
    held = salida_o;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({name, " hold"}, 64'(salida_o), 64'(held));
    end
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    out_ready_i = 1'b0;
    check({name, " handoff"}, 64'({out_valid_o, in_ready_o}), 64'b01);
  endtask

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{32'h0000_0001, 32'd5,  3'd0, 32'h0000_0020, 3};
    vecs[1]  = '{32'h8000_0000, 32'd31, 3'd2, 32'hFFFF_FFFF, 9};
    vecs[2]  = '{32'h8000_0000, 32'd31, 3'd1, 32'h0000_0001, 9};
    vecs[3]  = '{32'h0000_00F1, 32'd36, 3'd4, 32'h1000_000F, 2};
    vecs[4]  = '{32'h8000_0001, 32'd1,  3'd3, 32'h0000_0003, 2};
    vecs[5]  = '{32'hDEAD_BEEF, 32'd13, 3'd7, 32'hDEAD_BEEF, 1};
    vecs[6]  = '{32'hDEAD_BEEF, 32'd0,  3'd0, 32'hDEAD_BEEF, 1};
    vecs[7]  = '{32'h1234_5678, 32'd3,  3'd5, 32'h1234_5678, 1};
    vecs[8]  = '{32'h1234_5678, 32'd3,  3'd6, 32'h1234_5678, 1};
    vecs[9]  = '{32'h7000_0000, 32'd8,  3'd2, 32'h0070_0000, 3};
    vecs[10] = '{32'hF000_0000, 32'd4,  3'd2, 32'hFF00_0000, 2};
    vecs[11] = '{32'h1234_5678, 32'd8,  3'd3, 32'h3456_7812, 3};
    vecs[12] = '{32'hFFFF_FFFF, 32'd31, 3'd0, 32'h8000_0000, 9};
    vecs[13] = '{32'hFFFF_FFFF, 32'd32, 3'd1, 32'hFFFF_FFFF, 1};

    reset = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0;
    A = '0; B = '0; Operation = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset state", 64'({in_ready_o, out_valid_o, busy_o, salida_o}),
          64'({1'b1, 1'b0, 1'b0, 32'h0}));
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].cyc, vecs[i].res, i % 3,
             $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic [2:0]  rop;
      ra = $urandom; rb = $urandom; rop = 3'($urandom_range(0, 7));
      run_op(ra, rb, rop, ref_cycles(rb, rop), ref_shift(ra, rb, rop),
             int'($urandom_range(0, 2)), $sformatf("rnd%0d", i));
    end

    // Backpressure in DONE with in_valid_i pulsing.
    A = 32'h0000_0003; B = 32'd2; Operation = 3'd0; in_valid_i = 1'b1;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    for (int i = 0; i < 10 && !out_valid_o; i++) begin
      @(posedge clk); #1;
    end
    check("bp done", 64'(out_valid_o), 64'd1);
    for (int i = 0; i < 5; i++) begin
      A = $urandom; B = 32'd0; Operation = 3'd7; in_valid_i = 1'(i % 2);
      @(posedge clk); #1;
      check("bp stable", 64'({salida_o, in_ready_o, out_valid_o}),
            64'({32'h0000_000C, 1'b0, 1'b1}));
    end
    in_valid_i = 1'b1; out_ready_i = 1'b1;
    @(posedge clk); #1;
    in_valid_i = 1'b0; out_ready_i = 1'b0;
    check("bp release", 64'({in_ready_o, out_valid_o, busy_o, salida_o}),
          64'({1'b1, 1'b0, 1'b0, 32'h0000_000C}));

    // Reset mid-BUSY, with a competing request on the reset edge.
    A = 32'h0000_0001; B = 32'd20; Operation = 3'd0; in_valid_i = 1'b1;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    @(posedge clk); #1;
    check("mid busy", 64'(busy_o), 64'd1);
    reset = 1'b1; in_valid_i = 1'b1; out_ready_i = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    check("abort reset", 64'({in_ready_o, out_valid_o, busy_o, salida_o}),
          64'({1'b1, 1'b0, 1'b0, 32'h0}));
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("abort silent", 64'(out_valid_o), 64'd0);
    end
    run_op(32'h0000_0001, 32'd20, 3'd0, 6, 32'h0010_0000, 1, "post reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
